// File: rtl/scroll_marquee_if.sv
// Signal bundle between the scrolling-text engine and the code that feeds and displays it.
// The master side loads messages and controls scrolling; the slave side is the engine.
interface scroll_marquee_if #(
    parameter int DIGITS  = 4,
    parameter int MSG_LEN = 8,
    parameter int SYM_W   = 4
);
    localparam int LEN_W = $clog2(MSG_LEN + 1);
    localparam int POS_W = $clog2(MSG_LEN);

    logic                     load;
    logic [MSG_LEN*SYM_W-1:0] msg;
    logic [LEN_W-1:0]         msg_len;
    logic                     run;
    logic                     dir;
    logic [DIGITS*SYM_W-1:0]  nums;
    logic [POS_W-1:0]         pos;
    logic                     wrap;
    logic [DIGITS-1:0]        ssd_ctl;
    logic [SYM_W-1:0]         sym_out;

    modport master (
        output load, msg, msg_len, run, dir,
        input  nums, pos, wrap, ssd_ctl, sym_out
    );

    modport slave (
        input  load, msg, msg_len, run, dir,
        output nums, pos, wrap, ssd_ctl, sym_out
    );
endinterface

// File: rtl/scroll_marquee.sv
// Scrolling-text engine: DIGITS-wide window over a loadable message plus digit-scan drive.
// Define SCROLL_BOUNCE_EN for ping-pong scrolling instead of circular wrap.
module scroll_marquee #(
    parameter int DIGITS   = 4,
    parameter int MSG_LEN  = 8,
    parameter int SYM_W    = 4,
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 100000
) (
    input logic            clk,
    input logic            rst_n,
    scroll_marquee_if.slave bus
);
    localparam int LEN_W  = $clog2(MSG_LEN + 1);
    localparam int POS_W  = $clog2(MSG_LEN);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SUM_W  = $clog2(MSG_LEN + DIGITS) + 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MSG_LEN);

    logic [MSG_LEN*SYM_W-1:0] msg_q, msg_d;
    logic [LEN_W-1:0]         len_q, len_d, len_load, len_last;
    logic [POS_W-1:0]         pos_q, pos_d;
    logic [LEN_W-1:0]         pos_ext;
    logic [TICK_W-1:0]        tick_q, tick_d;
    logic                     step;
    logic                     wrap_q, wrap_d;
    logic [DIGITS*SYM_W-1:0]  nums_q, nums_d;
    logic [SUM_W-1:0]         win_idx;
    logic [SCAN_W-1:0]        scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]         scan_idx_q, scan_idx_d;
    logic [DIGITS-1:0]        ssd_q, ssd_d;
    logic [SYM_W-1:0]         sym_q, sym_d;

`ifdef SCROLL_BOUNCE_EN
    typedef enum logic {
        FWD = 1'b0,
        REV = 1'b1
    } dir_e;

    dir_e dir_q, dir_d;
`endif

    // Scroll prescaler: frozen while paused so the tick phase survives a pause.
    always_comb begin
        tick_d = tick_q;
        step   = 1'b0;
        if (bus.load) begin
            tick_d = '0;
        end else if (bus.run) begin
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                step   = 1'b1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    always_comb begin
        if (bus.msg_len == '0) begin
            len_load = LEN_W'(1);
        end else if (bus.msg_len > LEN_MAX) begin
            len_load = LEN_MAX;
        end else begin
            len_load = bus.msg_len;
        end
    end

    always_comb begin
        msg_d    = msg_q;
        len_d    = len_q;
        pos_d    = pos_q;
        wrap_d   = 1'b0;
        pos_ext  = LEN_W'(pos_q);
        len_last = len_q - 1'b1;
`ifdef SCROLL_BOUNCE_EN
        dir_d    = dir_q;
`endif
        if (bus.load) begin
            msg_d = bus.msg;
            len_d = len_load;
            pos_d = '0;
`ifdef SCROLL_BOUNCE_EN
            dir_d = bus.dir ? REV : FWD;
`endif
        end else if (step) begin
`ifdef SCROLL_BOUNCE_EN
            if (len_q == LEN_W'(1)) begin
                wrap_d = 1'b1;
            end else if (dir_q == FWD) begin
                if (pos_ext == len_last) begin
                    pos_d  = POS_W'(len_q - LEN_W'(2));
                    dir_d  = REV;
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end else begin
                if (pos_q == '0) begin
                    pos_d  = POS_W'(1);
                    dir_d  = FWD;
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_q - 1'b1;
                end
            end
`else
            if (!bus.dir) begin
                if (pos_ext == len_last) begin
                    pos_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end else begin
                if (pos_q == '0) begin
                    pos_d  = POS_W'(len_last);
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_q - 1'b1;
                end
            end
`endif
        end
    end

    // Window from the next-state values so nums lands on the same edge as pos.
    // (pos+k) mod len by repeated conditional subtraction; DIGITS passes cover len=1.
    always_comb begin
        nums_d  = '0;
        win_idx = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            win_idx = SUM_W'(pos_d) + SUM_W'(k);
            for (int unsigned j = 0; j < DIGITS; j++) begin
                if (win_idx >= SUM_W'(len_d)) begin
                    win_idx = win_idx - SUM_W'(len_d);
                end
            end
            nums_d[(DIGITS-1-k)*SYM_W +: SYM_W] = msg_d[win_idx*SYM_W +: SYM_W];
        end
    end

    // Scan drive uses next-state nums too, keeping sym_out aligned with nums and ssd_ctl.
    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
        end
        ssd_d = ~(DIGITS'(1) << (IDX_LAST - scan_idx_d));
        sym_d = nums_d[(IDX_LAST - scan_idx_d)*SYM_W +: SYM_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msg_q      <= '0;
            len_q      <= LEN_MAX;
            pos_q      <= '0;
            tick_q     <= '0;
            wrap_q     <= 1'b0;
            nums_q     <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            ssd_q      <= ~(DIGITS'(1) << IDX_LAST);
            sym_q      <= '0;
        end else begin
            msg_q      <= msg_d;
            len_q      <= len_d;
            pos_q      <= pos_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
            nums_q     <= nums_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            ssd_q      <= ssd_d;
            sym_q      <= sym_d;
        end
    end

`ifdef SCROLL_BOUNCE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_q <= bus.dir ? REV : FWD;
        end else begin
            dir_q <= dir_d;
        end
    end
`endif

    assign bus.nums    = nums_q;
    assign bus.pos     = pos_q;
    assign bus.wrap    = wrap_q;
    assign bus.ssd_ctl = ssd_q;
    assign bus.sym_out = sym_q;
endmodule

// File: tb/tb_scroll_marquee.sv
// Self-checking bench for scroll_marquee: stimulus queues cycle-stamped expected window
// states; a negedge monitor compares them, checks quiet cycles and the digit-scan outputs.
module tb_scroll_marquee;
    localparam int DIGITS   = 4;
    localparam int MSG_LEN  = 8;
    localparam int SYM_W    = 4;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    // Window for msg 0..6, len 7, indexed by pos
    localparam logic [15:0] N7 [7] = '{16'h0123, 16'h1234, 16'h2345, 16'h3456,
                                       16'h4560, 16'h5601, 16'h6012};
    // Window for msg 0..3 (len 4) and the ping-pong pos sequence after load
    localparam logic [15:0] N4 [4] = '{16'h0123, 16'h1230, 16'h2301, 16'h3012};
    localparam int          BP [7] = '{1, 2, 3, 2, 1, 0, 1};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scroll_marquee_if #(.DIGITS(DIGITS), .MSG_LEN(MSG_LEN), .SYM_W(SYM_W)) bus ();

    scroll_marquee #(
        .DIGITS(DIGITS), .MSG_LEN(MSG_LEN), .SYM_W(SYM_W),
        .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int          due;
        logic [2:0]  pos;
        logic [15:0] nums;
        logic        wrap;
    } exp_t;

    exp_t        sbq[$];
    exp_t        ent;
    int          cyc    = 0;
    int          tests  = 0;
    int          fails  = 0;
    bit          armed  = 1'b0;
    logic [2:0]  cur_pos  = '0;
    logic [15:0] cur_nums = '0;
    int          sc = 0;
    int          si = 0;
    logic [3:0]  exp_ssd;
    logic [3:0]  exp_sym;

    // Cycle stamp and reference model of the scan walker
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            sc <= 0;
            si <= 0;
        end else if (sc == SCAN_DIV - 1) begin
            sc <= 0;
            si <= (si + 1) % DIGITS;
        end else begin
            sc <= sc + 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                ent = sbq.pop_front();
                tests++;
                fails++;
                $display("FAIL missed_update due=%0d now=%0d required pos=%0d nums=%h",
                         ent.due, cyc, ent.pos, ent.nums);
            end
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                ent = sbq.pop_front();
                tests++;
                if ({bus.pos, bus.nums, bus.wrap} !== {ent.pos, ent.nums, ent.wrap}) begin
                    fails++;
                    $display("FAIL update@%0d pos/nums/wrap got %0d/%h/%b required %0d/%h/%b",
                             cyc, bus.pos, bus.nums, bus.wrap, ent.pos, ent.nums, ent.wrap);
                end
                cur_pos  = ent.pos;
                cur_nums = ent.nums;
            end else begin
                tests++;
                if ({bus.pos, bus.nums, bus.wrap} !== {cur_pos, cur_nums, 1'b0}) begin
                    fails++;
                    $display("FAIL hold@%0d pos/nums/wrap got %0d/%h/%b required %0d/%h/0",
                             cyc, bus.pos, bus.nums, bus.wrap, cur_pos, cur_nums);
                end
            end
            exp_ssd = ~(4'b1000 >> si);
            exp_sym = cur_nums[(3 - si)*4 +: 4];
            tests++;
            if ({bus.ssd_ctl, bus.sym_out} !== {exp_ssd, exp_sym}) begin
                fails++;
                $display("FAIL scan@%0d ssd_ctl/sym_out got %b/%h required %b/%h",
                         cyc, bus.ssd_ctl, bus.sym_out, exp_ssd, exp_sym);
            end
        end
    end

    function automatic void push(input int due, input int p, input logic [15:0] n, input bit w);
        exp_t e;
        e.due  = due;
        e.pos  = 3'(p);
        e.nums = n;
        e.wrap = w;
        sbq.push_back(e);
    endfunction

    task automatic wait_cyc(input int t);
        int guard;
        guard = 0;
        while (cyc < t && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic do_load(input logic [31:0] m, input logic [3:0] l, input logic r,
                           input logic d);
        bus.msg     = m;
        bus.msg_len = l;
        bus.run     = r;
        bus.dir     = d;
        bus.load    = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bus.load    = 1'b0;
        bus.msg     = '0;
        bus.msg_len = '0;
        bus.run     = 1'b0;
        bus.dir     = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push(cyc, 0, 16'h0000, 1'b0);
        armed = 1'b1;
        rst_n = 1'b1;
        wait_cyc(cyc + 2);

`ifndef SCROLL_BOUNCE_EN
        // Forward through len 7, wrapping 6 -> 0, steps 4 clk apart
        c = cyc;
        push(c + 1, 0, N7[0], 1'b0);
        for (int k = 1; k <= 8; k++) begin
            push(c + 1 + 4*k, k % 7, N7[k % 7], k == 7);
        end
        do_load(32'h0654_3210, 4'd7, 1'b1, 1'b0);
        wait_cyc(c + 33);
        bus.run = 1'b0;

        // Reverse, then flip to forward, then a 10-cycle pause mid-count
        c = cyc;
        push(c + 1,  0, N7[0], 1'b0);
        push(c + 5,  6, N7[6], 1'b1);
        push(c + 9,  5, N7[5], 1'b0);
        push(c + 13, 4, N7[4], 1'b0);
        push(c + 17, 5, N7[5], 1'b0);
        push(c + 31, 6, N7[6], 1'b0);
        do_load(32'h0654_3210, 4'd7, 1'b1, 1'b1);
        wait_cyc(c + 13);
        bus.dir = 1'b0;
        wait_cyc(c + 19);
        bus.run = 1'b0;
        wait_cyc(c + 29);
        bus.run = 1'b1;
        wait_cyc(c + 31);
        bus.run = 1'b0;

        // Load lands on the same edge as a step: load wins, no wrap
        c = cyc;
        bus.run = 1'b1;
        push(c + 4,  0, 16'hABCA, 1'b0);
        push(c + 8,  1, 16'hBCAB, 1'b0);
        push(c + 12, 2, 16'hCABC, 1'b0);
        push(c + 16, 0, 16'hABCA, 1'b1);
        wait_cyc(c + 3);
        do_load(32'h0000_0CBA, 4'd3, 1'b1, 1'b0);
        wait_cyc(c + 16);
        bus.run = 1'b0;

        // msg_len 0 acts as length 1: pos pinned at 0, wrap every step
        c = cyc;
        push(c + 1, 0, 16'hAAAA, 1'b0);
        push(c + 5, 0, 16'hAAAA, 1'b1);
        push(c + 9, 0, 16'hAAAA, 1'b1);
        do_load(32'h0000_0CBA, 4'd0, 1'b1, 1'b0);
        wait_cyc(c + 9);
        bus.run = 1'b0;

        // msg_len 15 clamps to 8: reverse from 0 lands on 7
        c = cyc;
        push(c + 1, 0, 16'h0123, 1'b0);
        push(c + 5, 7, 16'h7012, 1'b1);
        push(c + 9, 6, 16'h6701, 1'b0);
        do_load(32'h7654_3210, 4'd15, 1'b1, 1'b1);
        wait_cyc(c + 9);
        bus.run = 1'b0;
`else
        // Ping-pong over len 4; live dir changes after load are ignored
        c = cyc;
        push(c + 1, 0, N4[0], 1'b0);
        for (int k = 1; k <= 7; k++) begin
            push(c + 1 + 4*k, BP[k-1], N4[BP[k-1]], (k == 4) || (k == 7));
        end
        do_load(32'h7654_3210, 4'd4, 1'b1, 1'b0);
        bus.dir = 1'b1;
        wait_cyc(c + 29);
`endif

        // Reset on the edge where a step and a load would both occur
        c = cyc;
        bus.run = 1'b1;
        wait_cyc(c + 3);
        bus.msg     = 32'h0000_0CBA;
        bus.msg_len = 4'd3;
        bus.load    = 1'b1;
        rst_n       = 1'b0;
        push(c + 4, 0, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        bus.load = 1'b0;
        bus.run  = 1'b0;
        wait_cyc(cyc + 8);

        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain pending_entries got %0d required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/scroll_marquee.md
Name: scroll_marquee

Overview:
- Parametrised scrolling-text engine for the multi-digit seven-segment display.
- Holds a loadable message of up to MSG_LEN symbols and presents a DIGITS-wide window that advances one symbol per scroll tick, forward or reverse, with pause.
- Generates the digit-scan strobe and per-digit symbol code for the downstream segment decoder.
- All timing uses clock enables derived from `clk`; there are no derived clocks.

Parameters:
- DIGITS, 4, number of display digits (window width), ≥1
- MSG_LEN, 8, maximum message length in symbols, ≥2
- SYM_W, 4, bits per symbol code
- TICK_DIV, 50000000, clk cycles per scroll step
- SCAN_DIV, 100000, clk cycles per digit-scan step

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- load  in  1  single-cycle strobe; latch msg/msg_len, restart scroll
- msg  in  MSG_LEN*SYM_W  symbol i at bits [i*SYM_W +: SYM_W]
- msg_len  in  clog2(MSG_LEN+1)  active length, sampled on load
- run  in  1  1 = scroll, 0 = pause
- dir  in  1  0 = forward (window moves toward higher indices), 1 = reverse
- nums  out  DIGITS*SYM_W  window; digit 0 (leftmost) in MSBs
- pos  out  clog2(MSG_LEN)  index of the symbol shown on digit 0
- wrap  out  1  one-cycle pulse when pos wraps
- ssd_ctl  out  DIGITS  active-low one-hot digit enable; bit DIGITS-1 = digit 0
- sym_out  out  SYM_W  symbol for the currently enabled digit

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is synchronous and active-low. All state updates on the rising edge of `clk`.
- Reset values:
  - msg register all 0; len = MSG_LEN; pos = 0; prescaler = 0; scan index = 0.
  - nums = 0; wrap = 0; sym_out = 0; ssd_ctl = ~(1<<(DIGITS-1)).
- Prescaler:
  - Counts 0..TICK_DIV-1 only while run=1. step = 1 when run=1 and the count is TICK_DIV-1; the count then returns to 0.
  - run=0 holds the count, so pausing preserves the tick phase.
- Load:
  - load=1 latches msg and len; sets pos=0; clears the prescaler; suppresses wrap.
  - load has priority over a simultaneous step.
  - msg_len=0 is treated as 1; msg_len>MSG_LEN is clamped to MSG_LEN.
- Step, forward: pos = (pos==len-1) ? 0 : pos+1. Wrap pulses when pos goes from len-1 to 0.
- Step, reverse: pos = (pos==0) ? len-1 : pos-1. Wrap pulses when pos goes from 0 to len-1.
- dir is sampled at each step; a change takes effect on the next step with no extra delay.
- len=1: pos stays 0; wrap pulses on every step.
- Window: digit k shows msg[(pos+k) mod len], k = 0..DIGITS-1. Wrap-around repeats the message when DIGITS > len. The modulo is computed by iterative subtraction or compare, with no divider.
- Latency:
  - nums, pos and wrap are registered and update on the clk edge after the step/load cycle.
  - wrap is high for exactly 1 cycle.
- Scan:
  - An independent SCAN_DIV counter always runs, including when run=0.
  - The scan index cycles 0..DIGITS-1 and wraps to 0.
  - ssd_ctl and sym_out are registered together, so they are never skewed against each other. sym_out = nums digit[index].
- Reset mid-operation overrides load, step and scan in the same cycle.

Optional Feature:
- Macro: SCROLL_BOUNCE_EN.
- Defined (ping-pong mode):
  - Direction is held in an internal register, initialised from dir at reset and at load. The live dir input is ignored between loads.
  - Forward step at pos==len-1 moves to len-2 and switches to reverse. Reverse step at pos==0 moves to 1 and switches to forward.
  - wrap pulses on each reversal. len=1 keeps pos=0 and pulses wrap on every step.
- Undefined: circular wrap as described in Behaviour; no direction register.

Test Plan:
- TICK_DIV=4, DIGITS=4, MSG_LEN=8. Reset; load msg=0..6 with len=7, run=1, dir=0 → nums 0123, 1234, …, 6012, then 0123 again; wrap pulses once at 6→0; steps are exactly 4 clk apart.
- Same setup, dir=1 → sequence 0123, 6012, 5601; wrap pulses on 0→6.
- run held 0 for 10 clk mid-count, then 1 → step occurs after the remaining count (phase preserved); pos is unchanged during the pause.
- load asserted in the same cycle as a step, with len=3 and msg=A,B,C → pos=0, nums=ABCA, no wrap; msg_len=0 gives len=1 and nums=AAAA; msg_len=15 gives len=8.
- SCAN_DIV=2 → ssd_ctl walks 0111, 1011, 1101, 1110, repeating; sym_out matches nums digit per slot; scan continues while run=0.
- SCROLL_BOUNCE_EN defined, len=4, dir=0 → pos sequence 0,1,2,3,2,1,0,1; wrap pulses at 3→2 and 0→1; rst_n low mid-sequence → all reset values on the next edge.
